// File: rtl/addr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// addr_sequencer_pkg
// Shared definitions for the address sequencer: the FSM state enumeration
// and the default address width / address space size.
// ---------------------------------------------------------------------------
package addr_sequencer_pkg;

   localparam int DEFAULT_A = 8;
   localparam int DEFAULT_R = 256;   // always 2**DEFAULT_A

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : addr_sequencer_pkg

// File: rtl/addr_sequencer_if.sv
// ---------------------------------------------------------------------------
// addr_sequencer_if
// Bundles the burst request inputs and the address/strobe outputs of the
// address sequencer.
//   start  : burst request (only honoured while idle)
//   base   : first address of the burst
//   len    : number of addresses, 0 means the whole address space
//   step   : increment applied after every issued address
//   hold   : downstream stall, no address is issued while high
//   data   : address for the downstream address register
//   select : load strobe for the downstream address register
//   busy   : burst in progress (including the completion cycle)
//   done   : one-cycle pulse after the last address of a burst
// Modports: master drives the request side, slave is the sequencer.
// ---------------------------------------------------------------------------
interface addr_sequencer_if
   import addr_sequencer_pkg::*;
#(
   parameter int A = DEFAULT_A
);

   logic         start;
   logic [A-1:0] base;
   logic [A-1:0] len;
   logic [A-1:0] step;
   logic         hold;
   logic [A-1:0] data;
   logic         select;
   logic         busy;
   logic         done;

   modport master (
      output start, base, len, step, hold,
      input  data, select, busy, done
   );

   modport slave (
      input  start, base, len, step, hold,
      output data, select, busy, done
   );

endinterface : addr_sequencer_if

// File: rtl/addr_sequencer.sv
// ---------------------------------------------------------------------------
// addr_sequencer
// Issues a burst of addresses base, base+step, base+2*step, ... (modulo R)
// to a downstream address register held by the parent. One address is issued
// per cycle unless hold stalls the sequence. A done pulse follows the last
// address of a completed burst; a reset mid-burst silently aborts it.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : addr_sequencer_if slave modport (request in, address/strobe out)
// ---------------------------------------------------------------------------
module addr_sequencer
   import addr_sequencer_pkg::*;
#(
   parameter int A = DEFAULT_A,
   parameter int R = DEFAULT_R   // must equal 2**A
) (
   input  logic            clk,
   input  logic            reset,
   addr_sequencer_if.slave bus
);

   state_t       state_reg, state_next;
   logic [A-1:0] cur_reg,   cur_next;
   logic [A:0]   rem_reg,   rem_next;   // one extra bit so a full-space burst fits
   logic [A-1:0] step_reg,  step_next;
   logic         select;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cur_reg   <= '0;
         rem_reg   <= '0;
         step_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cur_reg   <= cur_next;
         rem_reg   <= rem_next;
         step_reg  <= step_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cur_next   = cur_reg;
      rem_next   = rem_reg;
      step_next  = step_reg;
      select     = (state_reg == RUN) && !bus.hold;

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               cur_next   = bus.base;
               // len of zero requests the whole address space
               rem_next   = (bus.len == '0) ? (A+1)'(R) : {1'b0, bus.len};
               step_next  = bus.step;
               state_next = RUN;
            end
         end
         RUN: begin
            if (select) begin
               // natural A-bit overflow gives the modulo-R wrap
               cur_next = cur_reg + step_reg;
               rem_next = rem_reg - (A+1)'(1);
               if (rem_reg == (A+1)'(1)) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.data   = cur_reg;
   assign bus.select = select;
   assign bus.busy   = (state_reg != IDLE);
   assign bus.done   = (state_reg == DONE);

endmodule : addr_sequencer

// File: tb/tb_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_addr_sequencer
// Self-checking bench for addr_sequencer: a table of per-cycle vectors for the
// basic, wrap, hold and start-while-busy bursts, hand-written sequences for
// the full-space burst and the mid-burst reset, then randomized traffic
// checked against a burst-level reference model.
// ---------------------------------------------------------------------------
module tb_addr_sequencer;

   localparam int A = 8;
   localparam int R = 256;

   logic clk;
   logic reset;

   addr_sequencer_if #(.A(A)) bus ();

   addr_sequencer #(.A(A), .R(R)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic       start;
      logic [7:0] base;
      logic [7:0] len;
      logic [7:0] step;
      logic       hold;
      logic [7:0] e_data;
      logic       e_sel;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic st, input logic [7:0] b, input logic [7:0] l,
                               input logic [7:0] s, input logic h, input logic [7:0] ed,
                               input logic es, input logic eb, input logic edn);
      vec_t v;
      v.start = st; v.base = b; v.len = l; v.step = s; v.hold = h;
      v.e_data = ed; v.e_sel = es; v.e_busy = eb; v.e_done = edn;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] ed, input logic es,
                        input logic eb, input logic edn);
      tests++;
      if (bus.data !== ed || bus.select !== es || bus.busy !== eb || bus.done !== edn) begin
         fails++;
         $display("FAIL %s: actual data=%02h select=%b busy=%b done=%b, required data=%02h select=%b busy=%b done=%b",
                  name, bus.data, bus.select, bus.busy, bus.done, ed, es, eb, edn);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: actual %0d, required %0d", name, act, req);
      end
   endtask

   task automatic drive(input logic st, input logic [7:0] b, input logic [7:0] l,
                        input logic [7:0] s, input logic h);
      bus.start = st; bus.base = b; bus.len = l; bus.step = s; bus.hold = h;
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // watchdog: every loop below is bounded, this only guards against a stuck run
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int         cnt;
      int         saw_done;
      int         abort_bad;
      logic [7:0] last;
      // reference model state (burst-level view)
      int m_active, m_done, m_k, m_n, m_base, m_step, m_idle;
      logic       r_rst, r_st, r_h;
      logic [7:0] r_b, r_l, r_s;
      int         e_data;

      reset = 1'b1;
      drive(0, 8'h00, 8'h00, 8'h00, 0);
      tick();
      #4;
      check("in_reset", 8'h00, 0, 0, 0);
      tick();
      reset = 1'b0;
      #4;
      check("after_reset", 8'h00, 0, 0, 0);
      tick();

      // ---- table-driven bursts: basic, wrap, hold, start ignored while busy ----
      vecs.push_back(mk(1, 8'h10, 8'd4, 8'd1, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h10, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h11, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h12, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h13, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h14, 0, 1, 1));
      vecs.push_back(mk(1, 8'hFE, 8'd4, 8'd1, 0, 8'h14, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'hFE, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'hFF, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h00, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h01, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h02, 0, 1, 1));
      vecs.push_back(mk(1, 8'h20, 8'd3, 8'd2, 0, 8'h02, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h20, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 1, 8'h22, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 1, 8'h22, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h22, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h24, 1, 1, 0));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h26, 0, 1, 1));
      vecs.push_back(mk(1, 8'h30, 8'd3, 8'd1, 0, 8'h26, 0, 0, 0));
      vecs.push_back(mk(1, 8'h80, 8'd7, 8'd5, 0, 8'h30, 1, 1, 0));
      vecs.push_back(mk(1, 8'h90, 8'd2, 8'd3, 0, 8'h31, 1, 1, 0));
      vecs.push_back(mk(1, 8'hA0, 8'd1, 8'd1, 0, 8'h32, 1, 1, 0));
      vecs.push_back(mk(1, 8'h40, 8'd2, 8'd3, 0, 8'h33, 0, 1, 1));
      vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 0, 8'h33, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].start, vecs[i].base, vecs[i].len, vecs[i].step, vecs[i].hold);
         #4;
         $display("[TB] vec %0d start=%b base=%02h len=%0d step=%0d hold=%b -> data=%02h select=%b busy=%b done=%b",
                  i, vecs[i].start, vecs[i].base, vecs[i].len, vecs[i].step, vecs[i].hold,
                  bus.data, bus.select, bus.busy, bus.done);
         check($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_sel, vecs[i].e_busy, vecs[i].e_done);
         tick();
      end

      // ---- len=0: whole address space ----
      drive(1, 8'h00, 8'd0, 8'd1, 0);
      #4;
      check("full_start", 8'h33, 0, 0, 0);
      tick();
      drive(0, 8'h00, 8'd0, 8'd0, 0);
      cnt = 0;
      saw_done = 0;
      last = 8'h00;
      for (int i = 0; i < 300 && saw_done == 0; i++) begin
         #4;
         if (bus.select === 1'b1) begin
            cnt++;
            last = bus.data;
         end
         if (bus.done === 1'b1) begin
            saw_done = 1;
            check("full_done_cycle", 8'h00, 0, 1, 1);
         end
         tick();
      end
      $display("[TB] full burst: %0d select cycles, last data=%02h, done seen=%0d", cnt, last, saw_done);
      check_int("full_count", cnt, 256);
      check_int("full_last", int'(last), 'hFF);
      check_int("full_done_seen", saw_done, 1);
      #4;
      check("full_idle", 8'h00, 0, 0, 0);
      tick();

      // ---- reset on the second issue cycle of a len=5 burst ----
      drive(1, 8'h50, 8'd5, 8'd1, 0);
      #4;
      tick();
      drive(0, 8'h00, 8'd0, 8'd0, 0);
      #4;
      check("abort_issue1", 8'h50, 1, 1, 0);
      tick();
      reset = 1'b1;
      #4;
      check("abort_issue2", 8'h51, 1, 1, 0);
      tick();
      reset = 1'b0;
      #4;
      check("abort_after", 8'h00, 0, 0, 0);
      tick();
      abort_bad = 0;
      for (int i = 0; i < 8; i++) begin
         #4;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) abort_bad++;
         tick();
      end
      $display("[TB] aborted burst: %0d idle cycles with done/busy raised", abort_bad);
      check_int("abort_no_done", abort_bad, 0);
      drive(1, 8'h60, 8'd2, 8'd1, 0);
      #4;
      tick();
      drive(0, 8'h00, 8'd0, 8'd0, 0);
      #4;
      check("post_abort_1", 8'h60, 1, 1, 0);
      tick();
      #4;
      check("post_abort_2", 8'h61, 1, 1, 0);
      tick();
      #4;
      check("post_abort_done", 8'h62, 0, 1, 1);
      tick();

      // ---- randomized traffic against the reference model ----
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_active = 0; m_done = 0; m_k = 0; m_n = 0; m_base = 0; m_step = 0; m_idle = 0;
      for (int c = 0; c < 3000; c++) begin
         r_rst = ($urandom_range(0, 63) == 0);
         r_st  = ($urandom_range(0, 3) == 0);
         r_h   = ($urandom_range(0, 2) == 0);
         r_b   = 8'($urandom);
         r_s   = 8'($urandom);
         r_l   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
         reset = r_rst;
         drive(r_st, r_b, r_l, r_s, r_h);
         #4;
         // burst-level view: the k-th issued address of a burst is base + k*step
         e_data = (m_active != 0) ? ((m_base + m_k * m_step) % R) : m_idle;
         check($sformatf("rand%0d", c), 8'(e_data), (m_active != 0) && !r_h,
               (m_active != 0) || (m_done != 0), m_done != 0);
         tick();
         if (r_rst) begin
            m_active = 0; m_done = 0; m_idle = 0;
         end else if (m_done != 0) begin
            m_done = 0;
         end else if (m_active != 0) begin
            if (!r_h) begin
               m_k++;
               if (m_k == m_n) begin
                  m_active = 0;
                  m_done   = 1;
                  m_idle   = (m_base + m_n * m_step) % R;
               end
            end
         end else if (r_st) begin
            m_active = 1;
            m_k      = 0;
            m_base   = int'(r_b);
            m_step   = int'(r_s);
            m_n      = (r_l == 8'd0) ? R : int'(r_l);
            $display("[TB] random burst at cycle %0d: base=%02h len=%0d step=%0d", c, r_b, m_n, r_s);
         end
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_addr_sequencer

// File: doc/addr_sequencer.md
ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 Parameter A, default 8, address width.
REQ-002 Parameter R, default 256, address space size, always equal to 2^A.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  burst request; sampled only in IDLE.
REQ-006 base  input  A  first address of burst; captured when start is accepted.
REQ-007 len  input  A  number of addresses in burst; 0 means R; captured with base.
REQ-008 step  input  A  address increment per issued address; captured with base.
REQ-009 hold  input  1  downstream stall; while high no address is issued.
REQ-010 data  output  A  address presented to the downstream address register's data input.
REQ-011 select  output  1  load strobe to the downstream address register; high means data is valid this cycle.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 done  output  1  one-cycle pulse after the last address is issued.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL, at the edge, capture base into cur, capture len into remaining (A+1 bits, with len=0 loaded as R), capture step, and enter RUN.
REQ-016 IDLE with start=0 SHALL leave all state unchanged.
REQ-017 data SHALL equal cur in every state; select SHALL equal (state==RUN && hold==0), driven combinationally from registered state and hold.
REQ-018 In RUN, each edge with select=1 SHALL update cur to (cur+step) mod R and decrement remaining by 1.
REQ-019 In RUN, an edge with hold=1 SHALL leave cur, remaining and state unchanged.
REQ-020 In RUN, an edge with select=1 and remaining==1 SHALL enter DONE; exactly len addresses (R when len=0) are issued per burst.
REQ-021 DONE SHALL assert done=1 and select=0 for exactly one cycle, then return to IDLE unconditionally.
REQ-022 start SHALL be ignored in RUN and DONE; a new burst can be accepted no earlier than the first IDLE cycle.
REQ-023 The first address SHALL appear with select=1 in the cycle immediately after the start edge when hold=0: one cycle of latency.
REQ-024 Address arithmetic SHALL wrap modulo R without flagging; step=0 SHALL issue base repeatedly, len times.
REQ-025 busy SHALL equal (state != IDLE).

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, cur=0, remaining=0 and step=0, overriding start and hold, including mid-burst.
REQ-027 While in reset and in the cycle after reset, data=0, select=0, busy=0 and done=0.
REQ-028 An aborted burst SHALL NOT produce a done pulse.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and the default A and R constants.
REQ-030 The block SHALL be a single module with no sub-modules; the downstream address register is instantiated by the parent, not inside this block.

Verification
REQ-031 The bench SHALL cover a basic burst: base=0x10, len=4, step=1, hold=0 -> select high for 4 consecutive cycles with data 0x10,0x11,0x12,0x13, then done=1 for one cycle, then IDLE.
REQ-032 The bench SHALL cover wrap-around: base=0xFE, len=4, step=1 -> data 0xFE,0xFF,0x00,0x01.
REQ-033 The bench SHALL cover hold: base=0x20, len=3, step=2, hold high during the second issue cycle for 2 cycles -> data 0x20, (2 cycles select=0 with data held at 0x22), 0x22, 0x24, then done.
REQ-034 The bench SHALL cover len=0, base=0, step=1 -> exactly 256 select cycles, last data 0xFF, then done.
REQ-035 The bench SHALL cover start pulsed during RUN with different base/len -> ignored; the original burst completes unchanged.
REQ-036 The bench SHALL cover reset asserted on the 2nd issue cycle of a len=5 burst -> next cycle IDLE, data=0, select=0, and no done pulse; a subsequent start then runs normally.
